// File: rtl/sensor_alarm_ctrl_if.sv
// Sensor/ack inputs and buzzer/status outputs of the alarm controller.
// The master side drives the sensors and consumes the status.
interface sensor_alarm_ctrl_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]  sensor;
    logic [N_CH-1:0]  ack;
    logic [N_CH-1:0]  buzzer;
    logic [N_CH-1:0]  active;
    logic             alarm_any;
    logic [CNT_W-1:0] alarm_cnt;

    modport master (output sensor, ack, input buzzer, active, alarm_any, alarm_cnt);
    modport slave  (input sensor, ack, output buzzer, active, alarm_any, alarm_cnt);
endinterface

// File: rtl/sensor_alarm_ctrl.sv
// N-channel debounced sensor-to-buzzer alarm controller with cadence, hold,
// per-channel mute and a saturating count of alarm entries.
module sensor_alarm_ctrl #(
    parameter int N_CH     = 8,
    parameter int DEB_CYC  = 3,
    parameter int ON_CYC   = 2,
    parameter int OFF_CYC  = 2,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ena,
    sensor_alarm_ctrl_if.slave bus
);
    localparam int PER = ON_CYC + OFF_CYC;
    localparam int DW  = $clog2(DEB_CYC + 1);
    localparam int CW  = $clog2(PER);
    localparam int HW  = $clog2(HOLD_CYC + 1);
    localparam int SW  = CNT_W + $clog2(N_CH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEB, S_ALARM, S_HOLD, S_MUTED
    } state_t;

    logic [N_CH-1:0]  w_enter;
    logic [N_CH-1:0]  w_buz;
    logic [N_CH-1:0]  w_act;
    logic [CNT_W-1:0] r_cnt;
    logic [SW-1:0]    w_sum;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t        r_st,   w_st;
        logic [DW-1:0] r_deb,  w_deb;
        logic [CW-1:0] r_cad,  w_cad, w_cad_inc;
        logic [HW-1:0] r_hold, w_hold;
        logic          w_ent;

        assign w_cad_inc = (r_cad == CW'(PER - 1)) ? '0 : r_cad + 1'b1;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_st   <= S_IDLE;
                r_deb  <= '0;
                r_cad  <= '0;
                r_hold <= '0;
            end else begin
                r_st   <= w_st;
                r_deb  <= w_deb;
                r_cad  <= w_cad;
                r_hold <= w_hold;
            end
        end

        always_comb begin
            w_st   = r_st;
            w_deb  = r_deb;
            w_cad  = r_cad;
            w_hold = r_hold;
            w_ent  = 1'b0;
            if (!i_ena) begin
                w_st   = S_IDLE;
                w_deb  = '0;
                w_cad  = '0;
                w_hold = '0;
            end else begin
                case (r_st)
                    S_IDLE: if (bus.sensor[g]) begin
                        if (DEB_CYC == 1) begin
                            w_st  = S_ALARM;
                            w_cad = '0;
                            w_ent = 1'b1;
                        end else begin
                            w_st  = S_DEB;
                            w_deb = DW'(1);
                        end
                    end
                    S_DEB: begin
                        if (!bus.sensor[g]) begin
                            w_st  = S_IDLE;
                            w_deb = '0;
                        end else if (r_deb + 1'b1 == DW'(DEB_CYC)) begin
                            w_st  = S_ALARM;
                            w_deb = '0;
                            w_cad = '0;
                            w_ent = 1'b1;
                        end else begin
                            w_deb = r_deb + 1'b1;
                        end
                    end
                    S_ALARM, S_HOLD: begin
                        // Cadence free-runs across ALARM<->HOLD so re-raise keeps phase.
                        w_cad = w_cad_inc;
                        if (bus.ack[g]) begin
                            w_st   = S_MUTED;
                            w_cad  = '0;
                            w_hold = '0;
                        end else if (r_st == S_ALARM) begin
                            if (!bus.sensor[g]) begin
                                w_st   = S_HOLD;
                                w_hold = '0;
                            end
                        end else if (bus.sensor[g]) begin
                            w_st = S_ALARM;
                        end else if (r_hold == HW'(HOLD_CYC - 1)) begin
                            w_st   = S_IDLE;
                            w_cad  = '0;
                            w_hold = '0;
                        end else begin
                            w_hold = r_hold + 1'b1;
                        end
                    end
                    S_MUTED: if (!bus.sensor[g]) w_st = S_IDLE;
                    default: w_st = S_IDLE;
                endcase
            end
        end

        assign w_enter[g] = w_ent;
        assign w_buz[g]   = ((r_st == S_ALARM) || (r_st == S_HOLD)) && (r_cad < CW'(ON_CYC));
        assign w_act[g]   = (r_st == S_ALARM) || (r_st == S_HOLD) || (r_st == S_MUTED);
    end

    always_comb begin
        w_sum = SW'(r_cnt);
        for (int i = 0; i < N_CH; i++) w_sum = w_sum + SW'(w_enter[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (w_sum > {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}})
            r_cnt <= '1;
        else
            r_cnt <= w_sum[CNT_W-1:0];
    end

    assign bus.buzzer    = w_buz;
    assign bus.active    = w_act;
    assign bus.alarm_any = |w_act;
    assign bus.alarm_cnt = r_cnt;
endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Directed-vector scoreboard bench: driver queues hand-computed expectations,
// monitor pops and compares one entry after each rising edge.
module tb_sensor_alarm_ctrl;
    logic clk = 1'b0;
    logic rst, ena;
    always #5 clk = ~clk;

    sensor_alarm_ctrl_if #(.N_CH(8), .CNT_W(8)) ifa ();
    sensor_alarm_ctrl_if #(.N_CH(8), .CNT_W(3)) ifb ();
    assign ifb.sensor = ifa.sensor;
    assign ifb.ack    = ifa.ack;

    sensor_alarm_ctrl #(.N_CH(8), .CNT_W(8)) dut_a (.i_clk(clk), .i_rst(rst), .i_ena(ena), .bus(ifa));
    sensor_alarm_ctrl #(.N_CH(8), .CNT_W(3)) dut_b (.i_clk(clk), .i_rst(rst), .i_ena(ena), .bus(ifb));

    typedef struct {
        logic [7:0] buz;
        logic [7:0] act;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int vec     = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL vec %0d %s: got %0h expected %0h", vec, nm, got, want);
        end
    endtask

    task automatic step(input logic e, input logic r, input logic [7:0] s, input logic [7:0] a,
                        input logic [7:0] eb, input logic [7:0] ea, input int ec);
        exp_t x;
        @(negedge clk);
        ena = e; rst = r; ifa.sensor = s; ifa.ack = a;
        x.buz = eb; x.act = ea; x.cnt = ec;
        q.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                vec++;
                chk("buzzer",       32'(ifa.buzzer),    32'(x.buz));
                chk("active",       32'(ifa.active),    32'(x.act));
                chk("alarm_any",    32'(ifa.alarm_any), 32'(|x.act));
                chk("alarm_cnt",    32'(ifa.alarm_cnt), 32'(x.cnt));
                chk("buzzer_w3",    32'(ifb.buzzer),    32'(x.buz));
                chk("alarm_cnt_w3", 32'(ifb.alarm_cnt), 32'(x.cnt > 7 ? 7 : x.cnt));
            end
        end
    end

    initial begin
        ena = 1'b1; rst = 1'b1; ifa.sensor = '0; ifa.ack = '0;
        // reset state
        step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        step(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        // ch0 debounce then cadence 1,1,0,0
        step(1, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        step(1, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 1);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 1);
        step(1, 0, 8'h01, 8'h00, 8'h00, 8'h01, 1);
        step(1, 0, 8'h01, 8'h00, 8'h00, 8'h01, 1);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 1);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 1);
        // ch1 two-cycle glitch
        step(1, 0, 8'h03, 8'h00, 8'h00, 8'h01, 1);
        step(1, 0, 8'h03, 8'h00, 8'h00, 8'h01, 1);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 1);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 1);
        // ch0 drop: four HOLD cycles with cadence, then idle
        step(1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1);
        step(1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1);
        step(1, 0, 8'h00, 8'h00, 8'h01, 8'h01, 1);
        step(1, 0, 8'h00, 8'h00, 8'h01, 8'h01, 1);
        step(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        // re-alarm, drop, re-raise inside hold keeps phase and count
        step(1, 0, 8'h01, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 8'h01, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 2);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 2);
        step(1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 2);
        step(1, 0, 8'h01, 8'h00, 8'h00, 8'h01, 2);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 2);
        step(1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 2);
        // ack mutes; release clears; ack in idle ignored
        step(1, 0, 8'h01, 8'h01, 8'h00, 8'h01, 2);
        step(1, 0, 8'h01, 8'h00, 8'h00, 8'h01, 2);
        step(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2);
        step(1, 0, 8'h00, 8'h01, 8'h00, 8'h00, 2);
        // simultaneous entries: +2 then +6 (width-3 counter saturates)
        step(1, 0, 8'h06, 8'h00, 8'h00, 8'h00, 2);
        step(1, 0, 8'h06, 8'h00, 8'h00, 8'h00, 2);
        step(1, 0, 8'h06, 8'h00, 8'h06, 8'h06, 4);
        step(1, 0, 8'hFF, 8'h00, 8'h06, 8'h06, 4);
        step(1, 0, 8'hFF, 8'h00, 8'h00, 8'h06, 4);
        step(1, 0, 8'hFF, 8'h00, 8'hF9, 8'hFF, 10);
        step(1, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 10);
        // ena low clears channels but keeps count; rst clears count
        step(0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 10);
        step(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
        // sensor still high after reset: full debounce again
        step(1, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
        step(1, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
        step(1, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8);
        step(1, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8);
        step(1, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 8);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #5;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sensor_alarm_ctrl.md
Name: sensor_alarm_ctrl

Overview:
- Parametrised N-channel sensor-to-buzzer alarm controller; next generation of the 8-sensor/8-buzzer top-level state machine.
- Adds per-channel debounce, a programmable on/off buzzer cadence, post-release hold time, per-channel acknowledge/mute, and a saturating global alarm-event counter.
- Sits behind ui_in (sensors) and drives uo_out (buzzers) inside the tt_um wrapper; status outputs go to the uio bus.

Parameters:
N_CH, 8, number of sensor/buzzer channels (>=1)
DEB_CYC, 3, consecutive high samples required to raise an alarm (>=1)
ON_CYC, 2, buzzer-high cycles per cadence period (>=1)
OFF_CYC, 2, buzzer-low cycles per cadence period (>=1)
HOLD_CYC, 4, cycles the alarm persists after the sensor drops (>=1)
CNT_W, 8, width of alarm_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  global enable; 0 acts as synchronous soft-clear of channel FSMs
sensor  input  N_CH  raw sensor levels, treated as synchronous
ack  input  N_CH  per-channel acknowledge, sampled each cycle
buzzer  output  N_CH  buzzer drive, cadenced
active  output  N_CH  channel in ALARM, HOLD or MUTED
alarm_any  output  1  OR of active
alarm_cnt  output  CNT_W  saturating count of alarm entries

Behaviour:
- One clock, synchronous active-high reset; all state updates on rising clk.
- Reset:
  - All FSMs go to IDLE; debounce, cadence and hold counters clear.
  - buzzer=0, active=0, alarm_any=0, alarm_cnt=0.
- Outputs are decoded only from registered state; no combinational path from sensor or ack.
- Per-channel FSM, states IDLE, DEBOUNCE, ALARM, HOLD, MUTED:
  - IDLE:
    - sensor=1: go to DEBOUNCE with deb_cnt=1.
    - If DEB_CYC=1, go directly to ALARM instead.
  - DEBOUNCE:
    - sensor=0: go to IDLE.
    - sensor=1 and deb_cnt+1 == DEB_CYC: go to ALARM.
    - Otherwise increment deb_cnt.
    - Result: first buzzer-high cycle follows the DEB_CYC-th consecutive high sample.
  - ALARM:
    - Cadence counter starts at phase 0 on entry.
    - buzzer=1 for ON_CYC cycles, then 0 for OFF_CYC cycles, then repeats.
    - sensor=0: go to HOLD, hold_cnt=0; cadence continues without restart.
  - HOLD:
    - Cadence continues.
    - sensor=1: return to ALARM without restarting cadence and without counting a new entry.
    - hold_cnt reaches HOLD_CYC-1 with sensor=0: go to IDLE, so buzzer is 0 from the next cycle.
  - MUTED:
    - buzzer=0, active=1.
    - sensor=0 sampled: go to IDLE.
- ack=1 in ALARM or HOLD goes to MUTED.
  - ack has priority over all other transitions of that channel.
  - ack is ignored in IDLE, DEBOUNCE and MUTED.
- ena=0:
  - All channels forced to IDLE next cycle, counters cleared, buzzer=0.
  - alarm_cnt is held, not cleared.
  - rst has priority over ena.
- alarm_cnt:
  - Adds the number of channels making DEBOUNCE/IDLE→ALARM in that cycle (population count).
  - Saturates at 2^CNT_W-1 and never wraps.
  - HOLD→ALARM re-entry does not count.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Reset mid-alarm: outputs return to 0 in the cycle after the reset edge.
  - A sensor still high after reset release starts a fresh debounce.
- Implementation: generate loop over N_CH plus popcount/saturating-adder logic (~200 lines).

Test Plan:
- Defaults; sensor[0]=1 from edge 1 for 20 cycles. Required:
  - buzzer[0]=0 through edge 2.
  - After edge 3, buzzer[0] pattern is 1,1,0,0,1,1,...
  - active[0]=1, alarm_cnt=1.
- Glitch: sensor[1] high for 2 edges, then low. Required: buzzer[1] never 1, active[1]=0, alarm_cnt unchanged.
- Hold: sensor[2] drops mid-ALARM. Required:
  - Cadence continues 4 more cycles.
  - Then buzzer[2]=0 and active[2]=0.
  - Re-raising sensor[2] within 4 cycles keeps the cadence phase and leaves alarm_cnt unchanged.
- Ack: pulse ack[2] during ALARM with sensor high. Required:
  - Next cycle buzzer[2]=0 while active[2]=1.
  - After sensor[2] drops, active[2]=0 the following cycle.
  - ack in IDLE has no effect.
- Simultaneous: sensor[2:1] rise together, then sensor=8'hFF. Required:
  - alarm_cnt steps by +2 in one cycle.
  - Later it steps by +6 when the other six channels enter ALARM in one cycle.
  - With CNT_W=3, alarm_cnt saturates at 7.
- Control: during active alarms, assert ena=0 for 1 cycle, then rst=1 for 1 cycle. Required:
  - ena=0: buzzers and active all 0; alarm_cnt kept.
  - rst=1: alarm_cnt=0.
  - Sensor still high after reset release: buzzer waits a full DEB_CYC again.
